// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic unit.
// Holds the default datapath width and the divider state encoding.
package calc_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/subtractor.sv
// Combinational unsigned subtractor, the counterpart of the calculator adder.
// borrow_o is the difference MSB, so operands are given one guard bit by the caller.
module subtractor #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    assign diff_o   = a_i - b_i;
    assign borrow_o = diff_o[WIDTH-1];

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero skips the iterations and reports all-ones quotient with the dividend as remainder.
module divider
    import calc_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_r_msb;

    // R never exceeds the divisor, so its guard bit only matters inside the trial subtraction.
    assign unused_r_msb = r_q[WIDTH];
    assign trial        = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    subtractor #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a_i     (trial),
        .b_i     ({1'b0, d_q}),
        .diff_o  (diff),
        .borrow_o(borrow)
    );

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d   = A;
                    d_d   = B;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH - 1);
                    dbz_d = 1'b0;
                    if (B == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = borrow ? trial : diff;
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the restoring divider: reset, results, latency, ignored inputs,
// mid-operation reset and a back-to-back sweep over a grid of operand pairs.
module tb_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Entered and left 1 time unit after a rising edge. lat counts edges from acceptance
    // to the first done (-1 if it never came); post_* are sampled on the edge after done.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic z,
                           output int lat, output logic post_done, output logic post_busy);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; q = 'x; r = 'x; z = 1'bx;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k; q = quotient; r = remainder; z = div_by_zero;
                break;
            end
        end
        @(posedge clk);
        #1 post_done = done; post_busy = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; A = 8'd5; B = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        reset = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic z, pd, pb; int lat;
        run_div(8'd200, 8'd7, q, r, z, lat, pd, pb);
        n_cmp++;
        if (q !== 8'd28 || r !== 8'd4 || z !== 1'b0) begin
            n_err++;
            $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0", q, r, z);
        end
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges, want 8", lat);
        end
        n_cmp++;
        if (pd !== 1'b0 || pb !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
            n_err++;
            $display("FAIL basic_after_done: got done=%b busy=%b q=%0d r=%0d, want 0 0 28 4",
                     pd, pb, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r; logic z, pd, pb; int lat;
        run_div(8'd255, 8'd1, q, r, z, lat, pd, pb);
        n_cmp++;
        if (q !== 8'd255 || r !== 8'd0 || lat !== 8) begin
            n_err++;
            $display("FAIL b2b_255_1: got q=%0d r=%0d lat=%0d, want q=255 r=0 lat=8", q, r, lat);
        end
        run_div(8'd3, 8'd10, q, r, z, lat, pd, pb);
        n_cmp++;
        if (q !== 8'd0 || r !== 8'd3 || lat !== 8) begin
            n_err++;
            $display("FAIL b2b_3_10: got q=%0d r=%0d lat=%0d, want q=0 r=3 lat=8", q, r, lat);
        end
    endtask

    task automatic test_div_by_zero();
        logic [7:0] q, r; logic z, pd, pb; int lat;
        run_div(8'd5, 8'd0, q, r, z, lat, pd, pb);
        n_cmp++;
        if (q !== 8'd255 || r !== 8'd5 || z !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_5_0: got q=%0d r=%0d dbz=%b, want q=255 r=5 dbz=1", q, r, z);
        end
        n_cmp++;
        if (lat !== 0 || pd !== 1'b0 || pb !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_timing: got lat=%0d done_after=%b busy_after=%b, want 0 0 0",
                     lat, pd, pb);
        end
        run_div(8'd9, 8'd3, q, r, z, lat, pd, pb);
        n_cmp++;
        if (q !== 8'd3 || r !== 8'd0 || z !== 1'b0 || lat !== 8) begin
            n_err++;
            $display("FAIL dbz_clear_9_3: got q=%0d r=%0d dbz=%b lat=%0d, want 3 0 0 8",
                     q, r, z, lat);
        end
    endtask

    task automatic test_ignored_inputs();
        int n_done = 0;
        int lat = -1;
        logic [7:0] q = 'x, r = 'x;
        A = 8'd100; B = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 A = 8'd250; B = 8'd0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 4) begin A = 8'd17; B = 8'd200; end
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) begin lat = k; q = quotient; r = remainder; end
            end
        end
        n_cmp++;
        if (q !== 8'd33 || r !== 8'd1 || lat !== 8) begin
            n_err++;
            $display("FAIL ignore_ab: got q=%0d r=%0d lat=%0d, want q=33 r=1 lat=8", q, r, lat);
        end
        n_cmp++;
        if (n_done !== 1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_start: got %0d done pulses busy=%b in DONE, want 1 pulse busy=1",
                     n_done, busy);
        end
        @(posedge clk);
        #1 start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_idle: got busy=%b after DONE, want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] q, r; logic z, pd, pb; int lat;
        int n_done = 0;
        A = 8'd100; B = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL abort_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d active cycles after reset, want 0", n_done);
        end
        @(posedge clk);
        #1;
        run_div(8'd100, 8'd3, q, r, z, lat, pd, pb);
        n_cmp++;
        if (q !== 8'd33 || r !== 8'd1 || z !== 1'b0 || lat !== 8) begin
            n_err++;
            $display("FAIL abort_restart: got q=%0d r=%0d dbz=%b lat=%0d, want 33 1 0 8",
                     q, r, z, lat);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] q, r, eq, er; logic z, ez, pd, pb; int lat, el;
        for (int a = 0; a < 256; a += 17) begin
            for (int b = 0; b < 256; b += 15) begin
                run_div(8'(a), 8'(b), q, r, z, lat, pd, pb);
                if (b == 0) begin
                    eq = 8'hff; er = 8'(a); ez = 1'b1; el = 0;
                end else begin
                    eq = 8'(a / b); er = 8'(a % b); ez = 1'b0; el = 8;
                end
                n_cmp++;
                if (q !== eq || r !== er || z !== ez || lat !== el || pd !== 1'b0 || pb !== 1'b0) begin
                    n_err++;
                    $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d done_after=%b, want q=%0d r=%0d dbz=%b lat=%0d done_after=0",
                             a, b, q, r, z, lat, pd, eq, er, ez, el);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_ignored_inputs();
        test_reset_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
